// File: rtl/rv_pkg.sv
// Shared fetch-stage types and constants: data width, reset PC, NOP encoding,
// the fetch FSM state type and the next-PC source selector.
package rv_pkg;

  localparam int              XLEN      = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_SEL_INC    = 2'd0,
    PC_SEL_BRANCH = 2'd1,
    PC_SEL_HOLD   = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus: one request at a time, req/gnt
// for the address phase and rvalid for the data phase.
interface if_fetch_stage_if #(
  parameter int XLEN = 32
) ();

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/pc_reg.sv
// Program counter register. The next-PC value is exported so the fetch stage
// can register the memory address in the same cycle the PC moves.
module pc_reg
  import rv_pkg::*;
#(
  parameter int              XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = rv_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_en,
  input  pc_sel_e         sel,
  input  logic [XLEN-1:0] pc_branch,
  input  logic [XLEN-1:0] hold_pc,
  output logic [XLEN-1:0] pc_q,
  output logic [XLEN-1:0] pc_d
);

  // Redirect targets are forced to word alignment, so the low bits never matter.
  logic unused_branch_lsbs;
  assign unused_branch_lsbs = ^pc_branch[1:0];

  // Next-PC mux: sequential increment, aligned redirect, or resume after a held response.
  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      case (sel)
        PC_SEL_INC:    pc_d = pc_q + XLEN'(32'd4);
        PC_SEL_BRANCH: pc_d = {pc_branch[XLEN-1:2], 2'b00};
        PC_SEL_HOLD:   pc_d = hold_pc + XLEN'(32'd4);
        default:       pc_d = pc_q;
      endcase
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: issues one instruction-memory read at a time,
// presents {pc, instr} to the IF/ID register, honours hazard stalls and
// EX redirects, including redirects that race an in-flight fetch.
module if_fetch_stage
  import rv_pkg::*;
#(
  parameter int              XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = rv_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              pc_src,
  input  logic [XLEN-1:0]   pc_branch,
  if_fetch_stage_if.master  imem,
  output logic [XLEN-1:0]   if_pc,
  output logic [XLEN-1:0]   if_instr,
  output logic              ifid_write,
  output logic              ifid_flush
);

  fetch_state_e    state_q, state_d;
  logic            kill_q, kill_d;
  logic            imem_req_q, imem_req_d;
  logic [XLEN-1:0] imem_addr_q, imem_addr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic            ifid_write_q, ifid_write_d;
  logic            ifid_flush_q, ifid_flush_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic            pc_load;
  pc_sel_e         pc_sel;
  logic [XLEN-1:0] pc_q, pc_d;

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .load_en   (pc_load),
    .sel       (pc_sel),
    .pc_branch (pc_branch),
    .hold_pc   (hold_pc_q),
    .pc_q      (pc_q),
    .pc_d      (pc_d)
  );

  // Next state, PC update and presentation; a redirect overrides everything else.
  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    ifid_write_d = 1'b0;
    ifid_flush_d = 1'b0;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    pc_load      = 1'b0;
    pc_sel       = PC_SEL_INC;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem.imem_gnt) state_d = WAIT;
        else               state_d = REQ;
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          if (kill_q) begin
            // Response belongs to a fetch issued before a redirect.
            kill_d  = 1'b0;
            state_d = REQ;
          end else if (!stall) begin
            if_pc_d      = pc_q;
            if_instr_d   = imem.imem_rdata;
            ifid_write_d = 1'b1;
            pc_load      = 1'b1;
            pc_sel       = PC_SEL_INC;
            state_d      = REQ;
          end else begin
            hold_pc_d    = pc_q;
            hold_instr_d = imem.imem_rdata;
            state_d      = HOLD;
          end
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (!stall) begin
          if_pc_d      = hold_pc_q;
          if_instr_d   = hold_instr_q;
          ifid_write_d = 1'b1;
          pc_load      = 1'b1;
          pc_sel       = PC_SEL_HOLD;
          state_d      = REQ;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pc_src) begin
      if_pc_d      = if_pc_q;
      if_instr_d   = if_instr_q;
      ifid_write_d = 1'b0;
      ifid_flush_d = 1'b1;
      hold_pc_d    = hold_pc_q;
      hold_instr_d = hold_instr_q;
      pc_load      = 1'b1;
      pc_sel       = PC_SEL_BRANCH;
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          // A request granted this cycle is already in flight: mark its data stale.
          if (imem.imem_gnt) begin
            kill_d  = 1'b1;
            state_d = WAIT;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            kill_d  = 1'b1;
            state_d = WAIT;
          end
        end
        HOLD:    state_d = REQ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Request outputs are registered from the upcoming state and PC.
  always_comb begin
    imem_req_d  = (state_d == REQ);
    imem_addr_d = pc_d;
  end

  // FSM, request and IF/ID output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      kill_q       <= 1'b0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
      if_pc_q      <= '0;
      if_instr_q   <= '0;
      ifid_write_q <= 1'b0;
      ifid_flush_q <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      kill_q       <= kill_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      ifid_write_q <= ifid_write_d;
      ifid_flush_q <= ifid_flush_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = imem_addr_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;
  assign ifid_write     = ifid_write_q;
  assign ifid_flush     = ifid_flush_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage. A transaction-level model tracks the
// expected next fetch address, the single outstanding read (and whether a
// redirect made it stale), any response parked during a stall, and the
// {pc, instr} that must appear on IF/ID one cycle after acceptance.
module tb_if_fetch_stage;
  import rv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        pc_src;
  logic [31:0] pc_branch;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        ifid_write;
  logic        ifid_flush;

  if_fetch_stage_if #(.XLEN(32)) imem_bus ();

  if_fetch_stage #(
    .XLEN     (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .pc_src     (pc_src),
    .pc_branch  (pc_branch),
    .imem       (imem_bus),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .ifid_write (ifid_write),
    .ifid_flush (ifid_flush)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] exp_addr, out_addr, held_pc, held_instr, exp_if_pc, exp_if_instr, salt;
  bit          outstanding, out_stale, held, exp_write, exp_flush;
  // Stimulus knobs (percent)
  int          p_gnt, p_rv, p_stall, p_src;
  bit          gap_check;
  int          cyc, last_wr_cyc, writes_total;
  bit          force_src;
  logic [31:0] force_target;
  bit          seen_fffc, seen_wrap;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ salt;
  endfunction

  function automatic bit chance(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic model_reset();
    exp_addr     = RST_PC;
    outstanding  = 1'b0;
    out_stale    = 1'b0;
    held         = 1'b0;
    exp_write    = 1'b0;
    exp_flush    = 1'b0;
    exp_if_pc    = 32'h0;
    exp_if_instr = 32'h0;
    last_wr_cyc  = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   imem_bus.imem_req, 32'd0);
    check_eq({tag, "_addr"},  imem_bus.imem_addr, RST_PC);
    check_eq({tag, "_pc"},    if_pc, 32'h0);
    check_eq({tag, "_instr"}, if_instr, 32'h0);
    check_eq({tag, "_write"}, ifid_write, 32'd0);
    check_eq({tag, "_flush"}, ifid_flush, 32'd0);
  endtask

  // Release reset on a falling edge; the following cycle is the IDLE cycle.
  task automatic release_reset(input bit stray_rvalid);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = stray_rvalid;
    imem_bus.imem_rdata  = 32'hDEAD_BEEF;
    stall                = 1'b0;
    pc_src               = 1'b0;
  endtask

  // One clock: check outputs against expectations, drive inputs, advance the model.
  task automatic cycle();
    logic        req_o;
    logic [31:0] addr_o, tgt, wr_pc, wr_instr;
    bit          g, rv, st, src, wr_next;
    @(negedge clk);
    cyc++;
    req_o  = imem_bus.imem_req;
    addr_o = imem_bus.imem_addr;

    check_eq("ifid_write", ifid_write, exp_write);
    check_eq("ifid_flush", ifid_flush, exp_flush);
    check_eq("if_pc", if_pc, exp_if_pc);
    check_eq("if_instr", if_instr, exp_if_instr);
    check_eq("imem_req", req_o, !outstanding && !held);
    if (req_o) check_eq("imem_addr", addr_o, exp_addr);
    if (ifid_write) begin
      if (gap_check && last_wr_cyc >= 0) check_eq("write_gap", cyc - last_wr_cyc, 32'd2);
      last_wr_cyc = cyc;
      writes_total++;
    end

    g   = req_o && chance(p_gnt);
    rv  = outstanding && chance(p_rv);
    st  = chance(p_stall);
    src = force_src || chance(p_src);
    tgt = force_src ? force_target : $urandom();
    force_src = 1'b0;
    imem_bus.imem_gnt    = g;
    imem_bus.imem_rvalid = rv;
    imem_bus.imem_rdata  = rv ? data_of(out_addr) : $urandom();
    stall     = st;
    pc_src    = src;
    pc_branch = tgt;

    wr_next  = 1'b0;
    wr_pc    = 32'h0;
    wr_instr = 32'h0;
    if (rv) begin
      outstanding = 1'b0;
      if (!out_stale && !src) begin
        if (!st) begin
          wr_next  = 1'b1;
          wr_pc    = out_addr;
          wr_instr = data_of(out_addr);
        end else begin
          held       = 1'b1;
          held_pc    = out_addr;
          held_instr = data_of(out_addr);
        end
        exp_addr = out_addr + 32'd4;
      end
    end else if (held) begin
      if (src) begin
        held = 1'b0;
      end else if (!st) begin
        held     = 1'b0;
        wr_next  = 1'b1;
        wr_pc    = held_pc;
        wr_instr = held_instr;
      end
    end
    if (req_o && g) begin
      outstanding = 1'b1;
      out_addr    = exp_addr;
      out_stale   = src;
      if (addr_o == 32'hFFFF_FFFC) seen_fffc = 1'b1;
      else if (seen_fffc && addr_o == 32'h0) seen_wrap = 1'b1;
    end
    if (src) begin
      exp_addr  = {tgt[31:2], 2'b00};
      out_stale = 1'b1;
    end
    exp_flush = src;
    exp_write = wr_next;
    if (wr_next) begin
      exp_if_pc    = wr_pc;
      exp_if_instr = wr_instr;
    end
  endtask

  task automatic set_knobs(input int g, input int rv, input int st, input int src);
    p_gnt   = g;
    p_rv    = rv;
    p_stall = st;
    p_src   = src;
  endtask

  initial begin
    reset                = 1'b0;
    stall                = 1'b0;
    pc_src               = 1'b0;
    pc_branch            = 32'h0;
    imem_bus.imem_gnt    = 1'b0;
    imem_bus.imem_rvalid = 1'b0;
    imem_bus.imem_rdata  = 32'h0;
    salt                 = 32'h0;
    cyc                  = 0;
    writes_total         = 0;
    force_src            = 1'b0;
    force_target         = 32'h0;
    seen_fffc            = 1'b0;
    seen_wrap            = 1'b0;
    gap_check            = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    release_reset(1'b0);

    // Zero-wait memory returning address as data: 0x0, 0x4, 0x8 ... every 2 cycles
    set_knobs(100, 100, 0, 0);
    gap_check = 1'b1;
    repeat (16) cycle();
    gap_check = 1'b0;

    // Zero-wait with stalls across responses
    set_knobs(100, 100, 30, 0);
    repeat (300) cycle();

    // Slow memory, stalls and redirects at random points
    salt = $urandom();
    set_knobs(40, 50, 25, 10);
    repeat (3000) cycle();

    // Zero-wait with frequent redirects, so they often coincide with rvalid/stall
    set_knobs(100, 100, 20, 15);
    repeat (500) cycle();

    // PC wrap: redirect near the top of the address space
    set_knobs(100, 100, 0, 0);
    seen_fffc    = 1'b0;
    seen_wrap    = 1'b0;
    force_src    = 1'b1;
    force_target = 32'hFFFF_FFF9;
    repeat (12) cycle();
    check_eq("wrap_to_zero", seen_wrap, 32'd1);

    // Reset asserted while a fetch is outstanding
    set_knobs(100, 0, 0, 0);
    for (int i = 0; i < 20 && !outstanding; i++) cycle();
    check_eq("reached_wait", outstanding, 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    release_reset(1'b1);
    set_knobs(100, 100, 0, 0);
    repeat (10) cycle();

    check_eq("liveness", writes_total > 200, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register. Owns the program counter and issues one instruction-memory request at a time over a req/gnt + rvalid handshake. Presents {pc, instr} plus write/flush controls to the IF/ID register. Handles hazard-unit stalls and branch/jump redirects from EX, including redirects that arrive while a fetch is still in flight.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
stall  input  1  hazard unit: hold PC and do not advance the IF/ID register
pc_src  input  1  EX: branch/jump taken this cycle
pc_branch  input  XLEN  EX: redirect target
imem_req  output  1  request valid
imem_addr  output  XLEN  request address, word-aligned
imem_gnt  input  1  memory accepts the request this cycle
imem_rvalid  input  1  read data valid; at least 1 cycle after gnt; at most one outstanding
imem_rdata  input  XLEN  fetched instruction
if_pc  output  XLEN  PC of the presented instruction (to IF/ID in)
if_instr  output  XLEN  presented instruction (to IF/ID instr)
ifid_write  output  1  IF/ID write enable; 1-cycle pulse when if_pc/if_instr are valid
ifid_flush  output  1  drives IF/ID reset input; 1-cycle pulse on redirect

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, pc=RESET_PC, kill=0, imem_req=0, imem_addr=RESET_PC, if_pc=0, if_instr=0, ifid_write=0, ifid_flush=0, hold regs=0.
- States:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req=1, imem_addr=pc. On imem_gnt go to WAIT.
  - WAIT: imem_req=0. Wait for imem_rvalid.
  - HOLD: response captured while stalled.
- imem_addr and req are registered; req stays high until gnt. Address is stable while req is high.
- WAIT and imem_rvalid:
  - kill=1: discard the data, clear kill, go to REQ with the (already redirected) pc.
  - stall=0: register if_pc=pc and if_instr=imem_rdata, pulse ifid_write the next cycle, set pc=pc+4, go to REQ.
  - stall=1: capture into hold_pc/hold_instr and go to HOLD. No ifid_write.
- HOLD and stall=0: present hold values, pulse ifid_write, set pc=hold_pc+4, go to REQ.
- Redirect (pc_src=1), any state, highest priority (over stall and rvalid):
  - pc = {pc_branch[XLEN-1:2],2'b00}.
  - ifid_flush pulses 1 cycle; ifid_write=0 that cycle.
  - In WAIT without a same-cycle rvalid: set kill=1, stay in WAIT.
  - In WAIT with a same-cycle rvalid, or in HOLD: drop the data and go to REQ.
  - In REQ without gnt: update imem_addr next cycle. No request is lost or duplicated.
  - In REQ with gnt: set kill=1 and go to WAIT.
- Stall in REQ/WAIT does not block the memory handshake; it only blocks presentation.
- pc+4 wraps modulo 2^XLEN. Address bits [1:0] are always 0.
- Throughput: one instruction per 2 cycles with zero-wait memory (gnt same cycle, rvalid next cycle).
- ifid_write and ifid_flush are never high in the same cycle.
- Reset mid-transaction: the state machine returns to IDLE immediately. Any later imem_rvalid while in IDLE/REQ is ignored.

Decomposition:
- Shared package rv_pkg:
  - XLEN
  - RESET_PC default
  - NOP encoding 32'h0000_0013
  - fetch_state_e enum {IDLE,REQ,WAIT,HOLD}
- Sub-module pc_reg: PC register with async active-low reset, load-enable, and a next-PC mux of pc+4 / pc_branch / hold_pc+4.
- FSM and output registers stay in if_fetch_stage.

Test Plan:
- Reset release, zero-wait memory returning addr-as-data → imem_addr sequence 0x0,0x4,0x8; ifid_write pulses every 2 cycles with if_pc=0x0,0x4,0x8 and if_instr equal to if_pc.
- stall=1 for 5 cycles across an rvalid at pc=0x8 → no ifid_write while stalled; one pulse with if_pc=0x8 the cycle after stall drops; next request to 0xC.
- pc_src=1, pc_branch=0x103 while in WAIT for 0x10 → ifid_flush pulse; returned 0x10 data dropped (no ifid_write); next request to 0x100.
- pc_src and imem_rvalid in the same cycle → data dropped, flush pulse, next req to the target; pc_src together with stall → redirect wins.
- Memory holds gnt low for 3 cycles → imem_req stays high with a constant imem_addr; exactly one rvalid consumed per gnt.
- Wrap and reset: pc=0xFFFF_FFFC fetch → next imem_addr=0x0; assert reset in WAIT → all outputs zero asynchronously; next fetch is at RESET_PC.
